dircc_avalon_st_packet_arbiter: RTL and testbench



---
 rtl/dircc_types_pkg.sv | 27 ++
 rtl/dircc_round_robin_arbiter.sv | 73 +++++++
 rtl/dircc_avalon_st_packet_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_dircc_avalon_st_packet_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dircc_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dircc_types_pkg
// Description : Shared DiRCC packet constants, arbiter state encoding and a
//               small index-width helper used by the packet arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dircc_types_pkg;

    // Every DiRCC packet is exactly this many words, sop on word 0 and eop
    // on the last word.
    localparam int DIRCC_PACKET_WORDS = 8;
    localparam int DIRCC_WORD_WIDTH   = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_FORWARD = 2'd1,
        ARB_DISCARD = 2'd2
    } arb_state_t;

    // Width of an index into n items; never collapses to zero bits.
    function automatic int dircc_index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : dircc_types_pkg
`default_nettype wire

// File: rtl/dircc_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dircc_round_robin_arbiter
// Description : Rotating-priority request selector. Holds the priority
//               pointer (the source after the one most recently granted)
//               and reports the first active request at or after it.
// Revision    : 1.0 - initial release
//
// Ports
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   i_request    : one request bit per source
//   i_update     : a grant is being issued to o_winner this cycle
//   o_winner     : index of the selected source (valid when o_any_request)
//   o_any_request: at least one request bit is set
// ============================================================================
module dircc_round_robin_arbiter
    import dircc_types_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = dircc_index_width(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] i_request,
    input  logic         i_update,
    output logic [W-1:0] o_winner,
    output logic         o_any_request
);

    localparam logic [W-1:0] c_LAST_INDEX = W'(N - 1);

    // Highest-priority index for the next decision. Advancing it at grant
    // time is equivalent to recording the grant at packet completion,
    // because no other grant can happen while a packet is locked.
    logic [W-1:0] r_ptr;

    logic [W-1:0] w_winner;
    logic         w_found;
    logic [W-1:0] w_idx;
    int           w_sum;

    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        w_sum    = 0;
        for (int k = 0; k < N; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = W'(w_sum);
            if (!w_found && i_request[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_update) begin
            r_ptr <= (w_winner == c_LAST_INDEX) ? '0 : w_winner + 1'b1;
        end
    end

    assign o_winner      = w_winner;
    assign o_any_request = |i_request;

endmodule : dircc_round_robin_arbiter
`default_nettype wire

// File: rtl/dircc_avalon_st_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dircc_avalon_st_packet_arbiter
// Description : Round-robin packet arbiter sharing one Avalon-ST sink among
//               NUM_INPUTS packet sources. Locks a source from sop to eop,
//               forwards its words with zero latency, enforces fixed-length
//               DiRCC framing (drops stray words, truncates long packets)
//               and issues no new grant while the node is booting.
// Revision    : 1.0 - initial release
//
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   i_booting             : node booting, blocks new grants
//   i_in_valid/data/sop/eop/empty : packed per-source Avalon-ST inputs
//   o_in_ready            : per-source ready (readyLatency 0)
//   o_out_valid/data/sop/eop/empty, i_out_ready : shared Avalon-ST output
//   o_grant_valid         : a source is locked
//   o_grant_channel       : index of the locked source
//   o_length_error        : one-cycle pulse on a short or over-long packet
//   o_framing_error       : one-cycle pulse when a stray word is dropped
//   o_packets_forwarded   : wrapping count of packets completed on output
// ============================================================================
module dircc_avalon_st_packet_arbiter
    import dircc_types_pkg::*;
#(
    parameter  int NUM_INPUTS   = 4,
    parameter  int DATA_WIDTH   = DIRCC_WORD_WIDTH,
    parameter  int EMPTY_WIDTH  = 2,
    parameter  int PACKET_WORDS = DIRCC_PACKET_WORDS,
    parameter  int COUNT_WIDTH  = 16,
    localparam int CH_W         = dircc_index_width(NUM_INPUTS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_booting,
    input  logic [NUM_INPUTS-1:0]             i_in_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  i_in_data,
    input  logic [NUM_INPUTS-1:0]             i_in_sop,
    input  logic [NUM_INPUTS-1:0]             i_in_eop,
    input  logic [NUM_INPUTS*EMPTY_WIDTH-1:0] i_in_empty,
    output logic [NUM_INPUTS-1:0]             o_in_ready,
    output logic                              o_out_valid,
    output logic [DATA_WIDTH-1:0]             o_out_data,
    output logic                              o_out_sop,
    output logic                              o_out_eop,
    output logic [EMPTY_WIDTH-1:0]            o_out_empty,
    input  logic                              i_out_ready,
    output logic                              o_grant_valid,
    output logic [CH_W-1:0]                   o_grant_channel,
    output logic                              o_length_error,
    output logic                              o_framing_error,
    output logic [COUNT_WIDTH-1:0]            o_packets_forwarded
);

    localparam int               CNT_W       = dircc_index_width(PACKET_WORDS);
    localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(PACKET_WORDS - 1);

    arb_state_t             r_state;
    logic                   r_grant_valid;
    logic [CH_W-1:0]        r_grant_channel;
    logic [CNT_W-1:0]       r_word_cnt;
    logic                   r_length_error;
    logic                   r_framing_error;
    logic [COUNT_WIDTH-1:0] r_packets;

    logic [NUM_INPUTS-1:0]  w_request;
    logic [NUM_INPUTS-1:0]  w_stray;
    logic [NUM_INPUTS-1:0]  w_stray_pick;
    logic [CH_W-1:0]        w_winner;
    logic                   w_any_request;
    logic                   w_grant;

    logic                   w_sel_valid;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_sop;
    logic                   w_sel_eop;
    logic [EMPTY_WIDTH-1:0] w_sel_empty;
    logic                   w_beat;

    // A packet may only start on a sop word; any other valid word seen while
    // idle is a stray that gets flushed.
    assign w_request    = i_in_valid & i_in_sop;
    assign w_stray      = i_in_valid & ~i_in_sop;
    // Isolate the lowest set bit so only one stray word is dropped per cycle.
    assign w_stray_pick = w_stray & (~w_stray + 1'b1);

    assign w_grant = (r_state == ARB_IDLE) && !i_booting && w_any_request;

    dircc_round_robin_arbiter #(
        .N (NUM_INPUTS)
    ) u_rr (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_request     (w_request),
        .i_update      (w_grant),
        .o_winner      (w_winner),
        .o_any_request (w_any_request)
    );

    // Mux of the locked source's stream.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_sop   = 1'b0;
        w_sel_eop   = 1'b0;
        w_sel_empty = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (r_grant_channel == CH_W'(k)) begin
                w_sel_valid = i_in_valid[k];
                w_sel_data  = i_in_data[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_sop   = i_in_sop[k];
                w_sel_eop   = i_in_eop[k];
                w_sel_empty = i_in_empty[k*EMPTY_WIDTH +: EMPTY_WIDTH];
            end
        end
    end

    assign w_beat = w_sel_valid && i_out_ready;

    // Zero-latency pass-through and per-source ready generation.
    always_comb begin
        o_in_ready  = '0;
        o_out_valid = 1'b0;
        o_out_data  = '0;
        o_out_sop   = 1'b0;
        o_out_eop   = 1'b0;
        o_out_empty = '0;
        case (r_state)
            ARB_FORWARD: begin
                o_out_valid = w_sel_valid;
                o_out_data  = w_sel_data;
                o_out_sop   = w_sel_sop;
                // The last permitted word always closes the packet so the
                // receiver never sees an over-long frame.
                o_out_eop   = w_sel_eop | (w_sel_valid && (r_word_cnt == c_LAST_WORD));
                o_out_empty = w_sel_empty;
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (r_grant_channel == CH_W'(k)) begin
                        o_in_ready[k] = i_out_ready;
                    end
                end
            end
            ARB_DISCARD: begin
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (r_grant_channel == CH_W'(k)) begin
                        o_in_ready[k] = 1'b1;
                    end
                end
            end
            default: begin
                if (!i_booting && !w_any_request) begin
                    o_in_ready = w_stray_pick;
                end
            end
        endcase
        // The stray flush path is combinational from the inputs; keep every
        // ready low while reset is held.
        if (!reset_n) begin
            o_in_ready = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ARB_IDLE;
            r_grant_valid   <= 1'b0;
            r_grant_channel <= '0;
            r_word_cnt      <= '0;
            r_length_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_packets       <= '0;
        end else begin
            r_length_error  <= 1'b0;
            r_framing_error <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (!i_booting) begin
                        if (w_any_request) begin
                            r_grant_channel <= w_winner;
                            r_grant_valid   <= 1'b1;
                            r_word_cnt      <= '0;
                            r_state         <= ARB_FORWARD;
                        end else if (|w_stray) begin
                            r_framing_error <= 1'b1;
                        end
                    end
                end
                ARB_FORWARD: begin
                    if (w_beat) begin
                        if (w_sel_eop) begin
                            r_state        <= ARB_IDLE;
                            r_grant_valid  <= 1'b0;
                            r_packets      <= r_packets + 1'b1;
                            r_length_error <= (r_word_cnt != c_LAST_WORD);
                        end else if (r_word_cnt == c_LAST_WORD) begin
                            // Truncated: output packet is closed, the rest
                            // of the source packet is flushed.
                            r_state        <= ARB_DISCARD;
                            r_packets      <= r_packets + 1'b1;
                            r_length_error <= 1'b1;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                ARB_DISCARD: begin
                    if (w_sel_valid && w_sel_eop) begin
                        r_state       <= ARB_IDLE;
                        r_grant_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_grant_valid       = r_grant_valid;
    assign o_grant_channel     = r_grant_channel;
    assign o_length_error      = r_length_error;
    assign o_framing_error     = r_framing_error;
    assign o_packets_forwarded = r_packets;

endmodule : dircc_avalon_st_packet_arbiter
`default_nettype wire

// File: tb/tb_dircc_avalon_st_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dircc_avalon_st_packet_arbiter
// Description : Directed self-checking bench for the DiRCC packet arbiter.
//               Four queue-backed sources feed the DUT; an output monitor
//               logs every accepted word, grants and error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dircc_avalon_st_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int EW = 2;
    localparam int CW = 16;

    logic            clk;
    logic            reset_n;
    logic            booting;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_sop;
    logic [N-1:0]    in_eop;
    logic [N*EW-1:0] in_empty;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_sop;
    logic            out_eop;
    logic [EW-1:0]   out_empty;
    logic            out_ready;
    logic            grant_valid;
    logic [1:0]      grant_channel;
    logic            length_error;
    logic            framing_error;
    logic [CW-1:0]   packets_forwarded;

    dircc_avalon_st_packet_arbiter #(
        .NUM_INPUTS   (N),
        .DATA_WIDTH   (DW),
        .EMPTY_WIDTH  (EW),
        .PACKET_WORDS (8),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .i_booting           (booting),
        .i_in_valid          (in_valid),
        .i_in_data           (in_data),
        .i_in_sop            (in_sop),
        .i_in_eop            (in_eop),
        .i_in_empty          (in_empty),
        .o_in_ready          (in_ready),
        .o_out_valid         (out_valid),
        .o_out_data          (out_data),
        .o_out_sop           (out_sop),
        .o_out_eop           (out_eop),
        .o_out_empty         (out_empty),
        .i_out_ready         (out_ready),
        .o_grant_valid       (grant_valid),
        .o_grant_channel     (grant_channel),
        .o_length_error      (length_error),
        .o_framing_error     (framing_error),
        .o_packets_forwarded (packets_forwarded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- source model: one word queue per source ----------------
    logic [DW-1:0] m_data  [N][64];
    logic          m_sop   [N][64];
    logic          m_eop   [N][64];
    logic [EW-1:0] m_empty [N][64];
    int            head [N];
    int            tail [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    end

    always_comb begin
        in_valid = '0;
        in_data  = '0;
        in_sop   = '0;
        in_eop   = '0;
        in_empty = '0;
        for (int i = 0; i < N; i++) begin
            in_valid[i]            = (head[i] != tail[i]);
            in_data[i*DW +: DW]    = m_data[i][head[i] % 64];
            in_sop[i]              = m_sop[i][head[i] % 64];
            in_eop[i]              = m_eop[i][head[i] % 64];
            in_empty[i*EW +: EW]   = m_empty[i][head[i] % 64];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                head[i] <= head[i] + 1;
            end
        end
    end

    // ---------------- output monitor ----------------
    logic [DW-1:0] lg_data  [256];
    logic          lg_sop   [256];
    logic          lg_eop   [256];
    logic [EW-1:0] lg_empty [256];
    int            out_n  = 0;
    int            glog [64];
    int            gn     = 0;
    int            le_cnt = 0;
    int            fe_cnt = 0;
    logic          gv_prev = 1'b0;

    // Sampled mid-cycle: a word presented with valid and ready here is
    // accepted at the following rising edge.
    always @(negedge clk) begin
        #1;
        if (reset_n && out_valid && out_ready) begin
            lg_data[out_n % 256]  = out_data;
            lg_sop[out_n % 256]   = out_sop;
            lg_eop[out_n % 256]   = out_eop;
            lg_empty[out_n % 256] = out_empty;
            out_n = out_n + 1;
        end
        if (grant_valid && !gv_prev) begin
            glog[gn % 64] = int'(grant_channel);
            gn = gn + 1;
        end
        gv_prev = grant_valid;
        if (length_error)  le_cnt = le_cnt + 1;
        if (framing_error) fe_cnt = fe_cnt + 1;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] wrd(input int s, input int pkt, input int k);
        return {4'hA, 4'(s), 8'(pkt), 16'(k)};
    endfunction

    task automatic push_pkt(input int s, input int pkt, input int nw, input bit first_sop);
        for (int k = 0; k < nw; k++) begin
            int slot;
            slot = tail[s] % 64;
            m_data[s][slot]  = wrd(s, pkt, k);
            m_sop[s][slot]   = first_sop && (k == 0);
            m_eop[s][slot]   = (k == nw - 1);
            m_empty[s][slot] = (k == nw - 1) ? 2'd3 : 2'd0;
            tail[s] = tail[s] + 1;
        end
    endtask

    task automatic wait_out(input int target, input int budget, input string tag);
        int c;
        c = 0;
        while (out_n < target && c < budget) begin
            @(negedge clk);
            c = c + 1;
        end
        check(tag, 64'(out_n >= target), 64'd1);
    endtask

    // Count logged words in [base, base+nw) that differ from packet (s,pkt).
    function automatic int pkt_mismatch(input int base, input int s, input int pkt, input int nw);
        int bad;
        bad = 0;
        for (int k = 0; k < nw; k++) begin
            if (lg_data[(base + k) % 256] !== wrd(s, pkt, k)) bad = bad + 1;
            if (lg_sop[(base + k) % 256] !== (k == 0)) bad = bad + 1;
            if (lg_eop[(base + k) % 256] !== (k == nw - 1)) bad = bad + 1;
        end
        return bad;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int gbase;
        int le0;
        int bad_rdy;
        int bad_val;
        int bad_gv;
        bit found;

        reset_n   = 1'b0;
        booting   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready",   64'(in_ready), 64'h0);
        check("rst_out_valid",  64'(out_valid), 64'h0);
        check("rst_grant_valid", 64'(grant_valid), 64'h0);
        check("rst_grant_ch",   64'(grant_channel), 64'h0);
        check("rst_pkts",       64'(packets_forwarded), 64'h0);
        check("rst_errors",     64'({length_error, framing_error}), 64'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- 1: single 8-word packet from source 0 ----
        base = out_n;
        push_pkt(0, 1, 8, 1'b1);
        #1;
        check("t1_no_ready_in_request_cycle", 64'(in_ready), 64'h0);
        check("t1_no_out_in_request_cycle", 64'(out_valid), 64'h0);
        @(negedge clk);
        check("t1_first_word_valid", 64'(out_valid), 64'h1);
        check("t1_first_word_sop",   64'(out_sop), 64'h1);
        check("t1_first_word_data",  64'(out_data), 64'(wrd(0, 1, 0)));
        check("t1_grant",            64'({grant_valid, grant_channel}), 64'({1'b1, 2'd0}));
        check("t1_ready_onehot",     64'(in_ready), 64'h1);
        wait_out(base + 8, 12, "t1_eight_beats");
        @(negedge clk);
        check("t1_words",        64'(pkt_mismatch(base, 0, 1, 8)), 64'h0);
        check("t1_eop_empty",    64'(lg_empty[(base + 7) % 256]), 64'h3);
        check("t1_pkts",         64'(packets_forwarded), 64'h1);
        check("t1_no_len_err",   64'(le_cnt), 64'h0);
        check("t1_no_frame_err", 64'(fe_cnt), 64'h0);
        check("t1_released",     64'(grant_valid), 64'h0);

        // ---- 2: all four sources, round-robin order after reset ----
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_pkts_cleared", 64'(packets_forwarded), 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        base  = out_n;
        gbase = gn;
        for (int s = 0; s < N; s++) push_pkt(s, 2, 8, 1'b1);
        wait_out(base + 32, 60, "t2_four_packets");
        @(negedge clk);
        check("t2_grant_order",
              64'({4'(glog[gbase % 64]), 4'(glog[(gbase + 1) % 64]),
                   4'(glog[(gbase + 2) % 64]), 4'(glog[(gbase + 3) % 64])}),
              64'h0123);
        check("t2_no_interleave",
              64'(pkt_mismatch(base, 0, 2, 8) + pkt_mismatch(base + 8, 1, 2, 8) +
                  pkt_mismatch(base + 16, 2, 2, 8) + pkt_mismatch(base + 24, 3, 2, 8)),
              64'h0);
        check("t2_pkts_four", 64'(packets_forwarded), 64'h4);
        base = out_n;
        push_pkt(0, 3, 8, 1'b1);
        wait_out(base + 8, 14, "t2_refill");
        @(negedge clk);
        check("t2_regrant_src0", 64'(glog[(gbase + 4) % 64]), 64'h0);
        check("t2_refill_words", 64'(pkt_mismatch(base, 0, 3, 8)), 64'h0);
        check("t2_pkts_five", 64'(packets_forwarded), 64'h5);

        // ---- 3: booting holds every source off ----
        booting = 1'b1;
        base  = out_n;
        gbase = gn;
        for (int s = 0; s < N; s++) push_pkt(s, 4, 8, 1'b1);
        bad_rdy = 0;
        bad_val = 0;
        bad_gv  = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready != '0) bad_rdy = bad_rdy + 1;
            if (out_valid)      bad_val = bad_val + 1;
            if (grant_valid)    bad_gv  = bad_gv + 1;
        end
        check("t3_boot_ready_low", 64'(bad_rdy), 64'h0);
        check("t3_boot_no_output", 64'(bad_val), 64'h0);
        check("t3_boot_no_grant",  64'(bad_gv), 64'h0);
        booting = 1'b0;
        @(negedge clk);
        check("t3_first_word_latency", 64'({out_valid, out_sop}), 64'h3);
        // Priority pointer sits after source 0 from the previous grant.
        check("t3_first_winner", 64'(out_data), 64'(wrd(1, 4, 0)));
        wait_out(base + 8, 9, "t3_packet_in_9_cycles");
        wait_out(base + 32, 40, "t3_drain");
        @(negedge clk);
        check("t3_order_words",
              64'(pkt_mismatch(base, 1, 4, 8) + pkt_mismatch(base + 8, 2, 4, 8) +
                  pkt_mismatch(base + 16, 3, 4, 8) + pkt_mismatch(base + 24, 0, 4, 8)),
              64'h0);
        check("t3_pkts", 64'(packets_forwarded), 64'd9);

        // ---- 4/5: over-long from source 1, short from source 2 ----
        base  = out_n;
        gbase = gn;
        le0   = le_cnt;
        push_pkt(1, 5, 10, 1'b1);
        push_pkt(2, 5, 5, 1'b1);
        wait_out(base + 13, 40, "t4_words_out");
        repeat (2) @(negedge clk);
        check("t4_trunc_words",  64'(pkt_mismatch(base, 1, 5, 8)), 64'h0);
        check("t4_trunc_empty0", 64'(lg_empty[(base + 7) % 256]), 64'h0);
        check("t4_short_words",  64'(pkt_mismatch(base + 8, 2, 5, 5)), 64'h0);
        check("t4_total_words",  64'(out_n - base), 64'd13);
        check("t4_src1_drained", 64'(tail[1] - head[1]), 64'h0);
        check("t4_grant_seq",    64'({4'(glog[gbase % 64]), 4'(glog[(gbase + 1) % 64])}), 64'h12);
        check("t4_len_err_twice", 64'(le_cnt - le0), 64'd2);
        check("t4_pkts",         64'(packets_forwarded), 64'd11);
        check("t5_idle_after",   64'({grant_valid, out_valid}), 64'h0);

        // ---- 6: stray word, then reset mid-packet ----
        le0 = fe_cnt;
        push_pkt(3, 6, 1, 1'b0);
        #1;
        check("t6_stray_ready", 64'(in_ready), 64'h8);
        check("t6_stray_not_forwarded", 64'(out_valid), 64'h0);
        @(negedge clk);
        check("t6_frame_err_pulse", 64'(framing_error), 64'h1);
        check("t6_stray_dropped",   64'(tail[3] - head[3]), 64'h0);
        @(negedge clk);
        check("t6_frame_err_one_cycle", 64'({framing_error, 32'(fe_cnt - le0)}), 64'h1);

        push_pkt(0, 7, 8, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (out_valid && out_data == wrd(0, 7, 3)) found = 1'b1;
        end
        check("t6_reached_word4", 64'(found), 64'h1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_in_ready",   64'(in_ready), 64'h0);
        check("t6_rst_out",        64'({out_valid, out_sop, out_eop, out_empty}), 64'h0);
        check("t6_rst_out_data",   64'(out_data), 64'h0);
        check("t6_rst_grant",      64'({grant_valid, grant_channel}), 64'h0);
        check("t6_rst_pkts",       64'(packets_forwarded), 64'h0);
        tail[0] = head[0];
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_idle_after_reset", 64'({grant_valid, out_valid, in_ready}), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dircc_avalon_st_packet_arbiter
`default_nettype wire
